mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter in front of a single RAM port
//
// Purpose:
//    Serialises instruction reads and data reads/writes onto one RAM port.
//    Data requests normally have priority. In the first IDLE cycle after a
//    data transaction completes, a pending instruction request wins instead,
//    so a continuously busy data side cannot starve instruction fetch.
//    A RAM ERROR drops the FSM back to IDLE with wait held high. The
//    requester retries by keeping its request asserted.
//
// Optional feature:
//    MEM_ARBITER_TIMEOUT_EN - a watchdog aborts a request state after
//    TIMEOUT_CYCLES cycles without ACCESS/ERROR and sets the sticky timeout
//    flag. Without it, timeout is tied low and request states wait forever.
//
// Ports:
//    CLK        system clock, rising edge
//    RST        asynchronous active-high reset
//    iREN       instruction read request
//    iaddr      instruction word address
//    iwait      low only in the cycle the instruction read completes
//    iload      instruction read data, zero while iwait is high
//    dREN/dWEN  data read/write request (write wins when both are high)
//    daddr      data word address
//    dstore     data write value
//    dwait      low only in the cycle the data access completes
//    dload      data read data, zero while dwait is high or on writes
//    ramREN     RAM read enable
//    ramWEN     RAM write enable
//    ramaddr    RAM address
//    ramstore   RAM write data
//    ramload    RAM read data
//    ramstate   RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
//    timeout    sticky watchdog abort flag
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      IREQ = 2'b01,
      DREQ = 2'b10
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'b10;
   localparam logic [1:0] RAM_ERROR  = 2'b11;

   state_t      state;
   logic [31:0] lat_addr;
   logic [31:0] lat_store;
   logic        lat_ren;
   logic        lat_wen;
   // Set by a data completion; gives iREN priority for exactly one IDLE cycle.
   logic        ipri;

   logic        in_req;
   logic        ram_access;
   logic        ram_error;
   logic        wd_hit;
   logic        i_done;
   logic        d_done;

   assign in_req     = (state != IDLE);
   assign ram_access = (ramstate == RAM_ACCESS);
   assign ram_error  = (ramstate == RAM_ERROR);

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wd_cnt;
   logic          timeout_r;

   // The hit fires on the TIMEOUT_CYCLES-th stalled request cycle, so the
   // FSM is already back in IDLE on the cycle after that one.
   assign wd_hit  = in_req && !ram_access && !ram_error &&
                    (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign timeout = timeout_r;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wd_cnt    <= '0;
         timeout_r <= 1'b0;
      end else if (!in_req || ram_access || ram_error) begin
         wd_cnt <= '0;
      end else if (wd_hit) begin
         wd_cnt    <= '0;
         timeout_r <= 1'b1;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign wd_hit     = 1'b0;
   assign timeout    = 1'b0;
   assign unused_cfg = |TIMEOUT_CYCLES;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_store <= '0;
         lat_ren   <= 1'b0;
         lat_wen   <= 1'b0;
         ipri      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ipri <= 1'b0;
               if (iREN && (ipri || !(dREN || dWEN))) begin
                  state     <= IREQ;
                  lat_addr  <= iaddr;
                  lat_store <= '0;
                  lat_ren   <= 1'b1;
                  lat_wen   <= 1'b0;
               end else if (dREN || dWEN) begin
                  // A simultaneous read and write request is treated as a write.
                  state     <= DREQ;
                  lat_addr  <= daddr;
                  lat_store <= dstore;
                  lat_ren   <= !dWEN;
                  lat_wen   <= dWEN;
               end
            end
            IREQ, DREQ: begin
               if (ram_access) begin
                  state <= IDLE;
                  ipri  <= (state == DREQ);
               end else if (ram_error || wd_hit) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM side is driven purely from the latched request, so a requester that
   // drops or changes its inputs mid-transaction cannot disturb the access.
   assign ramREN   = in_req && lat_ren;
   assign ramWEN   = in_req && lat_wen;
   assign ramaddr  = in_req ? lat_addr  : '0;
   assign ramstore = in_req ? lat_store : '0;

   assign i_done = (state == IREQ) && ram_access;
   assign d_done = (state == DREQ) && ram_access;

   assign iwait = !i_done;
   assign iload = i_done ? ramload : '0;
   assign dwait = !d_done;
   assign dload = (d_done && !lat_wen) ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scenarios plus randomized scoreboard for mem_arbiter
module tb_mem_arbiter;

   localparam logic [1:0] FREE = 2'b00;
   localparam logic [1:0] BUSY = 2'b01;
   localparam logic [1:0] ACC  = 2'b10;
   localparam logic [1:0] ERR  = 2'b11;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload = '0;
   logic [1:0]  ramstate = FREE;
   logic        timeout;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Cycle boundary: just after the rising edge, inputs for the new cycle are driven.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Apply RAM response for the current cycle, then move to the sampling point.
   task automatic drive_ram(input logic [1:0] st, input logic [31:0] ld);
      ramstate = st;
      ramload  = ld;
      @(negedge CLK);
   endtask

   // Scoreboard state for the randomized phase
   logic [31:0] ram_mem [16];
   logic [31:0] ref_mem [16];
   bit          i_act, d_act, d_wr, d_done_prev, exp_i;
   logic [31:0] i_a, d_a, d_s;
   int          i_age, d_age, quiet, op;

   initial begin
      // ---------------- reset state ----------------
      iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h80;
      tick(); drive_ram(ACC, 32'hA5A5A5A5);
      tick(); drive_ram(ACC, 32'hA5A5A5A5);
      check_eq("rst_iwait", iwait, 1);
      check_eq("rst_dwait", dwait, 1);
      check_eq("rst_iload", iload, 0);
      check_eq("rst_dload", dload, 0);
      check_eq("rst_ren", ramREN, 0);
      check_eq("rst_wen", ramWEN, 0);
      check_eq("rst_addr", ramaddr, 0);
      check_eq("rst_store", ramstore, 0);
      check_eq("rst_timeout", timeout, 0);
      tick(); RST = 1'b0; iREN = 1'b0; dREN = 1'b0; drive_ram(FREE, 0);
      check_eq("idle_ren", ramREN, 0);

      // ---------------- single instruction read, 2-cycle latency ----------------
      tick(); iREN = 1'b1; iaddr = 32'h40; drive_ram(FREE, 0);
      check_eq("i1_c1_iwait", iwait, 1);
      check_eq("i1_c1_ren", ramREN, 0);
      tick(); drive_ram(ACC, 32'hDEADBEEF);
      check_eq("i1_c2_iwait", iwait, 0);
      check_eq("i1_c2_iload", iload, 32'hDEADBEEF);
      check_eq("i1_c2_ren", ramREN, 1);
      check_eq("i1_c2_addr", ramaddr, 32'h40);
      tick(); iREN = 1'b0; drive_ram(FREE, 32'h55555555);
      check_eq("i1_c3_iwait", iwait, 1);
      check_eq("i1_c3_iload", iload, 0);
      check_eq("i1_c3_ren", ramREN, 0);

      // ---------------- data priority then instruction fairness ----------------
      tick(); iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80; drive_ram(FREE, 0);
      check_eq("pr_c1_ren", ramREN, 0);
      tick(); drive_ram(ACC, 32'h11111111);
      check_eq("pr_c2_addr", ramaddr, 32'h80);
      check_eq("pr_c2_dwait", dwait, 0);
      check_eq("pr_c2_dload", dload, 32'h11111111);
      check_eq("pr_c2_iwait", iwait, 1);
      tick(); drive_ram(FREE, 0);
      check_eq("pr_c3_ren", ramREN, 0);
      tick(); drive_ram(ACC, 32'h22222222);
      check_eq("pr_c4_addr", ramaddr, 32'h44);
      check_eq("pr_c4_iwait", iwait, 0);
      check_eq("pr_c4_iload", iload, 32'h22222222);
      check_eq("pr_c4_dwait", dwait, 1);
      tick(); iREN = 1'b0; dREN = 1'b0; drive_ram(FREE, 0);

      // ---------------- write wins over read ----------------
      tick(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h84; dstore = 32'h12345678; drive_ram(FREE, 0);
      tick(); drive_ram(ACC, 32'hFFFFFFFF);
      check_eq("wr_wen", ramWEN, 1);
      check_eq("wr_ren", ramREN, 0);
      check_eq("wr_store", ramstore, 32'h12345678);
      check_eq("wr_addr", ramaddr, 32'h84);
      check_eq("wr_dwait", dwait, 0);
      check_eq("wr_dload", dload, 0);
      tick(); dREN = 1'b0; dWEN = 1'b0; drive_ram(FREE, 0);

      // ---------------- BUSY x3, ERROR, retry ----------------
      tick(); iREN = 1'b1; iaddr = 32'h48; drive_ram(FREE, 0);
      for (int k = 0; k < 3; k++) begin
         tick(); drive_ram(BUSY, 32'h0BAD0BAD);
         check_eq("er_busy_iwait", iwait, 1);
         check_eq("er_busy_ren", ramREN, 1);
      end
      tick(); drive_ram(ERR, 32'h0BAD0BAD);
      check_eq("er_err_iwait", iwait, 1);
      check_eq("er_err_iload", iload, 0);
      tick(); drive_ram(FREE, 0);
      check_eq("er_idle_ren", ramREN, 0);
      tick(); drive_ram(ACC, 32'hCAFEF00D);
      check_eq("er_retry_iwait", iwait, 0);
      check_eq("er_retry_iload", iload, 32'hCAFEF00D);
      tick(); iREN = 1'b0; drive_ram(FREE, 0);
      check_eq("er_after_iwait", iwait, 1);

      // ---------------- async reset during DREQ ----------------
      tick(); dREN = 1'b1; daddr = 32'h88; drive_ram(FREE, 0);
      tick(); drive_ram(BUSY, 0);
      check_eq("ar_pre_ren", ramREN, 1);
      check_eq("ar_pre_addr", ramaddr, 32'h88);
      #2 RST = 1'b1;
      #1;
      check_eq("ar_ren", ramREN, 0);
      check_eq("ar_addr", ramaddr, 0);
      check_eq("ar_dwait", dwait, 1);
      tick(); drive_ram(ACC, 32'h77777777);
      check_eq("ar_hold_dwait", dwait, 1);
      check_eq("ar_hold_dload", dload, 0);
      tick(); RST = 1'b0; dREN = 1'b0; drive_ram(ACC, 32'h77777777);
      check_eq("ar_rel_dwait", dwait, 1);
      check_eq("ar_rel_ren", ramREN, 0);

`ifdef MEM_ARBITER_TIMEOUT_EN
      // ---------------- watchdog abort after 4 stalled cycles ----------------
      tick(); iREN = 1'b1; iaddr = 32'h4C; drive_ram(FREE, 0);
      for (int k = 0; k < 4; k++) begin
         tick(); drive_ram(BUSY, 0);
         check_eq("to_busy_ren", ramREN, 1);
         check_eq("to_busy_flag", timeout, 0);
      end
      tick(); drive_ram(BUSY, 0);
      check_eq("to_idle_ren", ramREN, 0);
      check_eq("to_flag", timeout, 1);
      check_eq("to_iwait", iwait, 1);
      tick(); iREN = 1'b0; drive_ram(BUSY, 0);
      check_eq("to_retry_ren", ramREN, 1);
      tick(); drive_ram(ACC, 32'h600D600D);
      check_eq("to_drop_iwait", iwait, 0);
      tick(); drive_ram(FREE, 0);
      check_eq("to_sticky", timeout, 1);
      tick(); RST = 1'b1; drive_ram(FREE, 0);
      check_eq("to_rst_flag", timeout, 0);
      tick(); RST = 1'b0; drive_ram(FREE, 0);
`else
      // ---------------- no watchdog: a long stall still completes ----------------
      tick(); iREN = 1'b1; iaddr = 32'h4C; drive_ram(FREE, 0);
      for (int k = 0; k < 10; k++) begin
         tick(); drive_ram(BUSY, 0);
         check_eq("nt_busy_ren", ramREN, 1);
         check_eq("nt_flag", timeout, 0);
      end
      // Requester drops mid-transaction; the latched read still completes.
      tick(); iREN = 1'b0; drive_ram(ACC, 32'h600D600D);
      check_eq("nt_drop_iwait", iwait, 0);
      check_eq("nt_drop_iload", iload, 32'h600D600D);
      tick(); drive_ram(FREE, 0);
      check_eq("nt_idle_ren", ramREN, 0);
`endif

      // ---------------- randomized traffic against a memory scoreboard ----------------
      // Instruction addresses carry bit 8 so the RAM address identifies the owner;
      // both sides share the word selected by address bits [3:0].
      for (int k = 0; k < 16; k++) begin
         ram_mem[k] = $urandom;
         ref_mem[k] = ram_mem[k];
      end
      i_act = 0; d_act = 0; d_wr = 0; d_done_prev = 0; exp_i = 0;
      i_a = '0; d_a = '0; d_s = '0; i_age = 0; d_age = 0; quiet = 0; op = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (!i_act && ($urandom_range(0, 1) == 1)) begin
            i_act = 1; i_a = 32'h100 | 32'($urandom_range(0, 15)); i_age = 0;
         end
         if (!d_act && ($urandom_range(0, 1) == 1)) begin
            d_act = 1; d_a = 32'($urandom_range(0, 15)); d_s = $urandom; d_age = 0;
            op = $urandom_range(0, 2);
            d_wr = (op != 0);
         end
         iREN   = i_act;
         iaddr  = i_act ? i_a : $urandom;
         dREN   = d_act && (op != 1);
         dWEN   = d_act && d_wr;
         daddr  = d_act ? d_a : $urandom;
         dstore = d_act ? d_s : $urandom;
         // Never more than two stalled cycles in a row, so the watchdog stays quiet.
         if (quiet >= 2) ramstate = ACC;
         else ramstate = 2'($urandom_range(0, 3));
         quiet = (ramstate == ACC || ramstate == ERR) ? 0 : quiet + 1;
         ramload = ramREN ? ram_mem[ramaddr[3:0]] : $urandom;
         @(negedge CLK);

         check_eq("rnd_excl", 32'(ramREN & ramWEN), 0);
         if (exp_i) begin
            check_eq("rnd_prio", 32'(ramREN && ramaddr[8]), 1);
            exp_i = 0;
         end
         if (d_done_prev) begin
            check_eq("rnd_idle", 32'(ramREN | ramWEN), 0);
            exp_i = i_act;
         end
         d_done_prev = 0;
         if (ramWEN) begin
            check_eq("rnd_wr_addr", ramaddr, d_a);
            check_eq("rnd_wr_data", ramstore, d_s);
            if (ramstate == ACC) ram_mem[ramaddr[3:0]] = ramstore;
         end
         if (!iwait) begin
            check_eq("rnd_i_owner", 32'(i_act), 1);
            check_eq("rnd_iload", iload, ref_mem[i_a[3:0]]);
            i_act = 0;
         end else begin
            check_eq("rnd_iload_gate", iload, 0);
         end
         if (!dwait) begin
            check_eq("rnd_d_owner", 32'(d_act), 1);
            if (d_wr) begin
               check_eq("rnd_dload_wr", dload, 0);
               ref_mem[d_a[3:0]] = d_s;
            end else begin
               check_eq("rnd_dload", dload, ref_mem[d_a[3:0]]);
            end
            d_act = 0;
            d_done_prev = 1;
         end else begin
            check_eq("rnd_dload_gate", dload, 0);
         end
         if (i_act) i_age++;
         if (d_act) d_age++;
         if (i_age > 60 || d_age > 60) begin
            check_eq("rnd_stall", 32'(i_age > d_age ? i_age : d_age), 0);
            break;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
